// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin, packet-granular write arbiter in front of a sync FIFO write port
// Optional per-packet header word (requester id) enabled by defining FIFO_WR_ARB_HDR_EN.
module fifo_wr_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     fifo_wr_data,
    output logic                 fifo_wr_ena,
    input  logic                 fifo_wr_full,
    output logic                 busy,
    output logic [$clog2(N)-1:0] cur_id
);
    localparam int IW = $clog2(N);

`ifdef FIFO_WR_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] cur_id_q, cur_id_d;
    logic [IW-1:0] last_id_q, last_id_d;

    logic          rr_found;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] rr_idx;

    // Search starts just after the last packet's owner so every requester gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = IW'((int'(last_id_q) + k) % N);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        last_id_d    = last_id_q;
        in_ready     = '0;
        fifo_wr_ena  = 1'b0;
        fifo_wr_data = in_data[int'(cur_id_q)*WIDTH +: WIDTH];
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    cur_id_d = rr_pick;
`ifdef FIFO_WR_ARB_HDR_EN
                    state_d  = S_HDR;
`else
                    state_d  = S_DATA;
`endif
                end
            end
`ifdef FIFO_WR_ARB_HDR_EN
            S_HDR: begin
                if (!fifo_wr_full) begin
                    fifo_wr_ena  = 1'b1;
                    fifo_wr_data = WIDTH'(cur_id_q);
                    state_d      = S_DATA;
                end
            end
`endif
            S_DATA: begin
                // Grant is held across in_valid gaps until the last beat is written.
                in_ready[cur_id_q] = ~fifo_wr_full;
                if (in_valid[cur_id_q] && !fifo_wr_full) begin
                    fifo_wr_ena = 1'b1;
                    if (in_last[cur_id_q]) begin
                        last_id_d = cur_id_q;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_id_q  <= '0;
            last_id_q <= IW'(N - 1);
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign cur_id = cur_id_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb with a behavioural FIFO fill model
// Works with or without FIFO_WR_ARB_HDR_EN defined.
module tb_fifo_wr_arb;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;
`ifdef FIFO_WR_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [7:0]   gap;
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic           clk          = 1'b0;
    logic           rst_n        = 1'b0;
    logic [N*W-1:0] in_data      = '0;
    logic [N-1:0]   in_valid     = '0;
    logic [N-1:0]   in_last      = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   fifo_wr_data;
    logic           fifo_wr_ena;
    logic           fifo_wr_full = 1'b0;
    logic           busy;
    logic [IW-1:0]  cur_id;

    int n_cmp      = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int wr_total   = 0;
    int fifo_cnt   = 0;
    int fifo_depth = 64;
    int rd_pend    = 0;
    logic [N-1:0] acc = '0;
    beat_t        pq [N][$];
    logic [W-1:0] exp_q [$];
    int           wr_cyc [$];

    fifo_wr_arb #(.N(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_ena  (fifo_wr_ena),
        .fifo_wr_full (fifo_wr_full),
        .busy         (busy),
        .cur_id       (cur_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_beat(input int id, input logic [W-1:0] d, input bit last, input int gap);
        beat_t b;
        b.gap  = 8'(gap);
        b.last = last;
        b.data = d;
        pq[id].push_back(b);
    endtask

    task automatic exp_hdr(input int id);
        if (HDR != 0) exp_q.push_back(W'(id));
    endtask

    task automatic exp_word(input logic [W-1:0] d);
        exp_q.push_back(d);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (pq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            #1;
            done = all_empty() && !busy && (exp_q.size() == 0);
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Producers: advance on an accepted beat, honour per-beat valid-low gaps.
    always @(posedge clk) begin
        beat_t b;
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (pq[i].size() > 0 && pq[i][0].gap != 8'd0) begin
                b = pq[i][0];
                b.gap = b.gap - 8'd1;
                pq[i][0] = b;
                in_valid[i] = 1'b0;
            end else if (pq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_last[i]  = pq[i][0].last;
                in_data[i*W +: W] = pq[i][0].data;
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'b0;
            end
        end
        fifo_wr_full = (fifo_cnt >= fifo_depth);
    end

    // Monitor / FIFO model: writes land on the next rising edge.
    always @(negedge clk) begin
        acc = in_valid & in_ready;
        if (rd_pend > 0 && fifo_cnt > 0) begin
            fifo_cnt--;
            rd_pend--;
        end
        if (rst_n && fifo_wr_ena) begin
            check("wr_while_full", {31'd0, fifo_wr_full}, 32'd0);
            wr_total++;
            wr_cyc.push_back(cyc);
            fifo_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_wr_data);
            end else begin
                check("fifo_data", {16'd0, fifo_wr_data}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d expected writes pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        int  w0;
        int  cnt;
        int  p;
        bit  ok;

        // Reset with every requester valid, then 0,1,2,3 in order.
        for (int i = 0; i < N; i++) begin
            add_beat(i, W'(16'h1000 + i), 1'b1, 0);
            exp_hdr(i);
            exp_word(W'(16'h1000 + i));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        check("rst_wr_ena", {31'd0, fifo_wr_ena}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cur_id", {30'd0, cur_id}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("first_busy", {31'd0, busy}, 32'd1);
        check("first_cur_id", {30'd0, cur_id}, 32'd0);
        wait_drain("t1_drain");

        // Round robin 0,1,3 then 0 again, one idle bubble between packets.
        wr_cyc.delete();
        add_beat(0, 16'h0A00, 1'b0, 0); add_beat(0, 16'h0A01, 1'b1, 0);
        add_beat(0, 16'h0D00, 1'b0, 0); add_beat(0, 16'h0D01, 1'b1, 0);
        add_beat(1, 16'h0B10, 1'b0, 0); add_beat(1, 16'h0B11, 1'b1, 0);
        add_beat(3, 16'h0C30, 1'b0, 0); add_beat(3, 16'h0C31, 1'b1, 0);
        exp_hdr(0); exp_word(16'h0A00); exp_word(16'h0A01);
        exp_hdr(1); exp_word(16'h0B10); exp_word(16'h0B11);
        exp_hdr(3); exp_word(16'h0C30); exp_word(16'h0C31);
        exp_hdr(0); exp_word(16'h0D00); exp_word(16'h0D01);
        wait_drain("t2_drain");
        p = 2 + HDR;
        check("t2_write_count", wr_cyc.size(), 4 * p);
        for (int k = 1; k < wr_cyc.size(); k++)
            check("t2_spacing", wr_cyc[k] - wr_cyc[k-1], (k % p == 0) ? 2 : 1);

        // Requester 2 stalls mid-packet; requester 1 must wait for its last beat.
        add_beat(2, 16'h2000, 1'b0, 0);
        add_beat(2, 16'h2001, 1'b0, 5);
        add_beat(2, 16'h2002, 1'b1, 0);
        exp_hdr(2); exp_word(16'h2000); exp_word(16'h2001); exp_word(16'h2002);
        exp_hdr(1); exp_word(16'h1100);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            #1;
            ok = busy && (cur_id == 2'd2);
        end
        check("t3_grant2", {31'd0, ok}, 32'd1);
        add_beat(1, 16'h1100, 1'b1, 0);
        cnt = 0;
        ok  = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (in_ready[1]) cnt++;
            ok = (pq[2].size() == 0);
        end
        check("t3_no_interleave", cnt, 0);
        check("t3_pkt2_done", {31'd0, ok}, 32'd1);
        wait_drain("t3_drain");

        // Full back-pressure: depth 4, no reads until stalled.
        fifo_cnt   = 0;
        fifo_depth = 4;
        w0 = wr_total;
        exp_hdr(0);
        for (int i = 0; i < 6; i++) begin
            add_beat(0, W'(16'h4000 + i), (i == 5), 0);
            exp_word(W'(16'h4000 + i));
        end
        repeat (15) @(negedge clk);
        #1;
        check("t4_writes_to_full", wr_total - w0, 4);
        check("t4_ready_low", {31'd0, in_ready[0]}, 32'd0);
        check("t4_wr_ena_low", {31'd0, fifo_wr_ena}, 32'd0);
        check("t4_busy_held", {31'd0, busy}, 32'd1);
        rd_pend = 2 + HDR;
        wait_drain("t4_drain");
        check("t4_total_writes", wr_total - w0, 6 + HDR);
        check("t4_fill_level", fifo_cnt, 4);
        fifo_depth = 64;
        fifo_cnt   = 0;

        // Header case: requester 3, two beats.
        add_beat(3, 16'hAAAA, 1'b0, 0);
        add_beat(3, 16'h5555, 1'b1, 0);
        exp_hdr(3); exp_word(16'hAAAA); exp_word(16'h5555);
        wait_drain("t5_drain");

        // Mid-packet reset of a 4-beat packet from requester 2.
        w0 = wr_total;
        for (int i = 0; i < 4; i++) add_beat(2, W'(16'h6000 + i), (i == 3), 0);
        exp_hdr(2); exp_word(16'h6000);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            #1;
            ok = (wr_total == w0 + 1 + HDR);
        end
        check("t6_beat1_written", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #3;
        check("t6_ready_before_rst", {31'd0, in_ready[2]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_ready_async", {28'd0, in_ready}, 32'd0);
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        check("t6_wr_ena_async", {31'd0, fifo_wr_ena}, 32'd0);
        for (int i = 0; i < N; i++) pq[i].delete();
        fifo_cnt = 0;
        rd_pend  = 0;
        repeat (2) @(posedge clk);
        add_beat(2, 16'h6200, 1'b1, 0);
        add_beat(0, 16'h6100, 1'b1, 0);
        exp_hdr(0); exp_word(16'h6100);
        exp_hdr(2); exp_word(16'h6200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t6_regrant_busy", {31'd0, busy}, 32'd1);
        check("t6_regrant_id", {30'd0, cur_id}, 32'd0);
        wait_drain("t6_drain");

        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
